axi_id_pool_mc: RTL and testbench

//  Free-list allocator for AXI transaction IDs on the spy/issue side. It hands out one free ID
//  per cycle and accepts up to NUM_DEALLOC returns per cycle, e.g. port 0 = B channel, port 1 = R last.
//  It tracks ownership in an in-use bitmap. A double-free or a free of a never-issued ID is detected, dropped and flagged.

---
 rtl/axi_id_pool_pkg.sv | 28 ++
 rtl/axi_id_pool_ret_merge.sv | 58 +++++
 rtl/axi_id_pool_mc.sv | 120 ++++++++++++
 tb/tb_axi_id_pool_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_id_pool_pkg.sv
// Shared widths, types and helpers for the AXI ID free-list allocator.
package axi_id_pool_pkg;

   localparam int ID_WIDTH_DEF    = 4;
   localparam int ID_COUNT_DEF    = 1 << ID_WIDTH_DEF;
   localparam int NUM_DEALLOC_DEF = 2;

   localparam int PTR_W = $clog2(ID_COUNT_DEF);
   localparam int CNT_W = $clog2(ID_COUNT_DEF + 1);

   typedef logic [ID_WIDTH_DEF-1:0] id_t;
   typedef logic [PTR_W-1:0]        ptr_t;
   typedef logic [CNT_W-1:0]        cnt_t;

   // Widest ownership bitmap the popcount helper accepts.
   localparam int POP_MAX = 64;

   // Number of set bits; used to relate free_count to the ownership bitmap.
   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < POP_MAX; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/axi_id_pool_ret_merge.sv
// Return-port arbitration: decides which returned IDs are legal and where each
// accepted ID lands relative to the current queue tail.
module axi_id_pool_ret_merge #(
   parameter int ID_WIDTH    = 4,
   parameter int ID_COUNT    = 16,
   parameter int NUM_DEALLOC = 2,
   parameter int OFF_W       = $clog2(NUM_DEALLOC + 1)
) (
   input  logic [NUM_DEALLOC-1:0]          dealloc_req,
   input  logic [NUM_DEALLOC*ID_WIDTH-1:0] dealloc_id,
   input  logic [ID_COUNT-1:0]             in_use,
   output logic [NUM_DEALLOC-1:0]          accept,
   output logic [NUM_DEALLOC*OFF_W-1:0]    wr_off,
   output logic [OFF_W-1:0]                n_acc
);

   localparam int                ID_SPACE = 1 << ID_WIDTH;
   localparam logic [ID_WIDTH:0] ID_LIM   = (ID_WIDTH + 1)'(ID_COUNT);

   logic [ID_SPACE-1:0] in_use_ext_s;
   logic [ID_WIDTH-1:0] id_p_s;
   logic                ok_p_s;

   // Widen the bitmap to the full ID space so any ID value indexes safely.
   always_comb begin
      in_use_ext_s                = '0;
      in_use_ext_s[ID_COUNT-1:0]  = in_use;
   end

   // Walk ports in priority order: accept owned, in-range IDs not already taken
   // by a lower port; each port's write offset is the count of earlier accepts.
   always_comb begin
      accept = '0;
      wr_off = '0;
      n_acc  = '0;
      id_p_s = '0;
      ok_p_s = 1'b0;
      for (int p = 0; p < NUM_DEALLOC; p++) begin
         id_p_s = dealloc_id[p*ID_WIDTH +: ID_WIDTH];
         ok_p_s = dealloc_req[p] && ({1'b0, id_p_s} < ID_LIM) && in_use_ext_s[id_p_s];
         for (int q = 0; q < p; q++) begin
            if (accept[q] && (dealloc_id[q*ID_WIDTH +: ID_WIDTH] == id_p_s)) begin
               ok_p_s = 1'b0;
            end else begin
               ok_p_s = ok_p_s;
            end
         end
         wr_off[p*OFF_W +: OFF_W] = n_acc;
         if (ok_p_s) begin
            accept[p] = 1'b1;
            n_acc     = n_acc + OFF_W'(1'b1);
         end else begin
            accept[p] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_id_pool_mc.sv
// AXI transaction-ID free-list allocator: one grant per cycle from the queue
// head, up to NUM_DEALLOC returns per cycle appended at the tail, with an
// ownership bitmap that rejects double frees and frees of never-issued IDs.
module axi_id_pool_mc
   import axi_id_pool_pkg::*;
#(
   parameter int ID_WIDTH    = ID_WIDTH_DEF,
   parameter int ID_COUNT    = 1 << ID_WIDTH,
   parameter int NUM_DEALLOC = NUM_DEALLOC_DEF
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            alloc_req,
   output logic                            alloc_valid,
   output logic [ID_WIDTH-1:0]             alloc_id,
   input  logic [NUM_DEALLOC-1:0]          dealloc_req,
   input  logic [NUM_DEALLOC*ID_WIDTH-1:0] dealloc_id,
   output logic [NUM_DEALLOC-1:0]          dealloc_err,
   output logic                            err_sticky,
   output logic [$clog2(ID_COUNT+1)-1:0]   free_count
);

   localparam int QPTR_W = $clog2(ID_COUNT);
   localparam int QCNT_W = $clog2(ID_COUNT + 1);
   localparam int OFF_W  = $clog2(NUM_DEALLOC + 1);

   logic [ID_WIDTH-1:0]    queue_q [ID_COUNT];
   logic [ID_WIDTH-1:0]    queue_d [ID_COUNT];
   logic [QPTR_W-1:0]      head_q, head_d;
   logic [QPTR_W-1:0]      tail_q, tail_d;
   logic [QCNT_W-1:0]      free_count_q, free_count_d;
   logic [ID_COUNT-1:0]    in_use_q, in_use_d;
   logic [NUM_DEALLOC-1:0] dealloc_err_q, dealloc_err_d;
   logic                   err_sticky_q, err_sticky_d;

   logic                         alloc_fire_s;
   logic [NUM_DEALLOC-1:0]       accept_s;
   logic [NUM_DEALLOC*OFF_W-1:0] wr_off_s;
   logic [OFF_W-1:0]             n_acc_s;
   logic [ID_WIDTH-1:0]          ret_id_s;
   logic [QPTR_W-1:0]            wr_idx_s;

   axi_id_pool_ret_merge #(
      .ID_WIDTH    (ID_WIDTH),
      .ID_COUNT    (ID_COUNT),
      .NUM_DEALLOC (NUM_DEALLOC),
      .OFF_W       (OFF_W)
   ) u_ret_merge (
      .dealloc_req (dealloc_req),
      .dealloc_id  (dealloc_id),
      .in_use      (in_use_q),
      .accept      (accept_s),
      .wr_off      (wr_off_s),
      .n_acc       (n_acc_s)
   );

   // Grant side is driven purely from registered state; returns this cycle
   // cannot be granted until the following cycle.
   always_comb begin
      alloc_valid  = (free_count_q != '0);
      alloc_id     = queue_q[head_q];
      alloc_fire_s = alloc_req && alloc_valid;
   end

   // Next-state: pop on grant, append accepted returns in port order, update
   // ownership, count and error flags.
   always_comb begin
      queue_d  = queue_q;
      in_use_d = in_use_q;
      ret_id_s = '0;
      wr_idx_s = '0;

      head_d = alloc_fire_s ? (head_q + QPTR_W'(1'b1)) : head_q;
      in_use_d[alloc_id[QPTR_W-1:0]] = alloc_fire_s ? 1'b1 : in_use_q[alloc_id[QPTR_W-1:0]];

      for (int p = 0; p < NUM_DEALLOC; p++) begin
         ret_id_s = dealloc_id[p*ID_WIDTH +: ID_WIDTH];
         wr_idx_s = tail_q + QPTR_W'(wr_off_s[p*OFF_W +: OFF_W]);
         queue_d[wr_idx_s] = accept_s[p] ? ret_id_s : queue_d[wr_idx_s];
         in_use_d[ret_id_s[QPTR_W-1:0]] = accept_s[p] ? 1'b0 : in_use_d[ret_id_s[QPTR_W-1:0]];
      end

      tail_d        = tail_q + QPTR_W'(n_acc_s);
      free_count_d  = free_count_q - QCNT_W'(alloc_fire_s) + QCNT_W'(n_acc_s);
      dealloc_err_d = dealloc_req & ~accept_s;
      err_sticky_d  = err_sticky_q | (|dealloc_err_d);
   end

   // State registers; reset refills the queue with 0..ID_COUNT-1 and forgets
   // every outstanding ID.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ID_COUNT; i++) begin
            queue_q[i] <= ID_WIDTH'(i);
         end
         head_q        <= '0;
         tail_q        <= '0;
         free_count_q  <= QCNT_W'(ID_COUNT);
         in_use_q      <= '0;
         dealloc_err_q <= '0;
         err_sticky_q  <= 1'b0;
      end else begin
         queue_q       <= queue_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         free_count_q  <= free_count_d;
         in_use_q      <= in_use_d;
         dealloc_err_q <= dealloc_err_d;
         err_sticky_q  <= err_sticky_d;
      end
   end

   // Status outputs straight from their registers.
   always_comb begin
      free_count  = free_count_q;
      dealloc_err = dealloc_err_q;
      err_sticky  = err_sticky_q;
   end

endmodule

// File: tb/tb_axi_id_pool_mc.sv
// Directed and randomised checks of the AXI ID free-list allocator: a default
// 16-ID / 2-port instance for the directed scenarios and an 8-ID / 3-port
// instance for the long mixed run with a mid-run reset.
module tb_axi_id_pool_mc;
   import axi_id_pool_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Default instance (16 IDs, 2 return ports)
   logic       reset_n;
   logic       alloc_req;
   logic       alloc_valid;
   id_t        alloc_id;
   logic [1:0] dealloc_req;
   logic [7:0] dealloc_id;
   logic [1:0] dealloc_err;
   logic       err_sticky;
   cnt_t       free_count;

   // Small instance (8 IDs, 3 return ports)
   logic        reset_n_b;
   logic        alloc_req_b;
   logic        alloc_valid_b;
   logic [3:0]  alloc_id_b;
   logic [2:0]  dealloc_req_b;
   logic [11:0] dealloc_id_b;
   logic [2:0]  dealloc_err_b;
   logic        err_sticky_b;
   logic [3:0]  free_count_b;

   axi_id_pool_mc dut (
      .clk (clk), .reset_n (reset_n), .alloc_req (alloc_req), .alloc_valid (alloc_valid),
      .alloc_id (alloc_id), .dealloc_req (dealloc_req), .dealloc_id (dealloc_id),
      .dealloc_err (dealloc_err), .err_sticky (err_sticky), .free_count (free_count)
   );

   axi_id_pool_mc #(.ID_WIDTH (4), .ID_COUNT (8), .NUM_DEALLOC (3)) dut_b (
      .clk (clk), .reset_n (reset_n_b), .alloc_req (alloc_req_b), .alloc_valid (alloc_valid_b),
      .alloc_id (alloc_id_b), .dealloc_req (dealloc_req_b), .dealloc_id (dealloc_id_b),
      .dealloc_err (dealloc_err_b), .err_sticky (err_sticky_b), .free_count (free_count_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      alloc_req   = 1'b0;
      dealloc_req = 2'b00;
      dealloc_id  = 8'h00;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (alloc_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid: got %b want 1", alloc_valid); end
      n_checks++; if (alloc_id !== 4'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", alloc_id); end
      n_checks++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL reset_free: got %0d want 16", free_count); end
      n_checks++; if (dealloc_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", dealloc_err); end
      n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
   endtask

   task automatic test_alloc_all();
      alloc_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (alloc_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid[%0d]: got %b want 1", i, alloc_valid); end
         n_checks++; if (alloc_id !== 4'(i)) begin n_fail++; $display("FAIL t1_id[%0d]: got %0d want %0d", i, alloc_id, i); end
         step();
      end
      n_checks++; if (alloc_valid !== 1'b0) begin n_fail++; $display("FAIL t1_empty_valid: got %b want 0", alloc_valid); end
      n_checks++; if (free_count !== 5'd0) begin n_fail++; $display("FAIL t1_empty_free: got %0d want 0", free_count); end
      step();
      n_checks++; if (free_count !== 5'd0) begin n_fail++; $display("FAIL t1_ignored_req: got %0d want 0", free_count); end
      alloc_req = 1'b0;
   endtask

   task automatic test_dual_return();
      dealloc_req = 2'b11;
      dealloc_id  = {4'd9, 4'd5};
      step();
      dealloc_req = 2'b00;
      n_checks++; if (free_count !== 5'd2) begin n_fail++; $display("FAIL t2_free: got %0d want 2", free_count); end
      n_checks++; if (dealloc_err !== 2'b00) begin n_fail++; $display("FAIL t2_err: got %b want 00", dealloc_err); end
      n_checks++; if (alloc_id !== 4'd5) begin n_fail++; $display("FAIL t2_first: got %0d want 5", alloc_id); end
      alloc_req = 1'b1;
      step();
      n_checks++; if (alloc_id !== 4'd9) begin n_fail++; $display("FAIL t2_second: got %0d want 9", alloc_id); end
      n_checks++; if (free_count !== 5'd1) begin n_fail++; $display("FAIL t2_free1: got %0d want 1", free_count); end
      step();
      alloc_req = 1'b0;
      n_checks++; if (alloc_valid !== 1'b0) begin n_fail++; $display("FAIL t2_drained: got %b want 0", alloc_valid); end
   endtask

   task automatic test_dup_return();
      dealloc_req = 2'b11;
      dealloc_id  = {4'd3, 4'd3};
      step();
      dealloc_req = 2'b00;
      n_checks++; if (dealloc_err !== 2'b10) begin n_fail++; $display("FAIL t3_err: got %b want 10", dealloc_err); end
      n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL t3_sticky: got %b want 1", err_sticky); end
      n_checks++; if (free_count !== 5'd1) begin n_fail++; $display("FAIL t3_free: got %0d want 1", free_count); end
      n_checks++; if (alloc_id !== 4'd3) begin n_fail++; $display("FAIL t3_id: got %0d want 3", alloc_id); end
      step();
      n_checks++; if (dealloc_err !== 2'b00) begin n_fail++; $display("FAIL t3_pulse: got %b want 00", dealloc_err); end
      n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL t3_sticky_hold: got %b want 1", err_sticky); end
   endtask

   task automatic test_alloc_at_empty();
      alloc_req = 1'b1;
      step();
      n_checks++; if (free_count !== 5'd0) begin n_fail++; $display("FAIL t4_empty: got %0d want 0", free_count); end
      dealloc_req = 2'b01;
      dealloc_id  = {4'd0, 4'd7};
      step();
      n_checks++; if (free_count !== 5'd1) begin n_fail++; $display("FAIL t4_free: got %0d want 1", free_count); end
      n_checks++; if (alloc_valid !== 1'b1) begin n_fail++; $display("FAIL t4_valid: got %b want 1", alloc_valid); end
      n_checks++; if (alloc_id !== 4'd7) begin n_fail++; $display("FAIL t4_id: got %0d want 7", alloc_id); end
      n_checks++; if (dealloc_err !== 2'b00) begin n_fail++; $display("FAIL t4_err: got %b want 00", dealloc_err); end
      // Return of the very ID being granted this cycle sees it as free: rejected.
      step();
      alloc_req   = 1'b0;
      dealloc_req = 2'b00;
      n_checks++; if (free_count !== 5'd0) begin n_fail++; $display("FAIL t4_same_free: got %0d want 0", free_count); end
      n_checks++; if (dealloc_err !== 2'b01) begin n_fail++; $display("FAIL t4_same_err: got %b want 01", dealloc_err); end
   endtask

   task automatic test_never_issued();
      do_reset();
      n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL t5_sticky_reset: got %b want 0", err_sticky); end
      dealloc_req = 2'b01;
      dealloc_id  = {4'd0, 4'd4};
      step();
      dealloc_req = 2'b00;
      n_checks++; if (dealloc_err !== 2'b01) begin n_fail++; $display("FAIL t5_err: got %b want 01", dealloc_err); end
      n_checks++; if (free_count !== 5'd16) begin n_fail++; $display("FAIL t5_free: got %0d want 16", free_count); end
      n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: got %b want 1", err_sticky); end
      alloc_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (alloc_id !== 4'(i)) begin n_fail++; $display("FAIL t5_order[%0d]: got %0d want %0d", i, alloc_id, i); end
         step();
      end
      alloc_req = 1'b0;
      n_checks++; if (dealloc_err !== 2'b00) begin n_fail++; $display("FAIL t5_pulse: got %b want 00", dealloc_err); end
   endtask

   task automatic test_random();
      logic [7:0] m_use;
      logic [7:0] n_use;
      logic       m_sticky;
      logic [2:0] exp_err;
      logic [2:0] acc;
      logic [3:0] idp;
      logic       ok;
      logic       fire;
      int         pc;

      reset_n_b     = 1'b0;
      alloc_req_b   = 1'b0;
      dealloc_req_b = 3'b000;
      dealloc_id_b  = 12'h000;
      step();
      reset_n_b = 1'b1;
      m_use     = 8'h00;
      m_sticky  = 1'b0;

      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc == 5000) begin
            reset_n_b     = 1'b0;
            alloc_req_b   = 1'b0;
            dealloc_req_b = 3'b000;
            step();
            reset_n_b = 1'b1;
            m_use     = 8'h00;
            m_sticky  = 1'b0;
            n_checks++; if (alloc_id_b !== 4'd0) begin n_fail++; $display("FAIL t6_rst_id: got %0d want 0", alloc_id_b); end
            n_checks++; if (free_count_b !== 4'd8) begin n_fail++; $display("FAIL t6_rst_free: got %0d want 8", free_count_b); end
            n_checks++; if (alloc_valid_b !== 1'b1) begin n_fail++; $display("FAIL t6_rst_valid: got %b want 1", alloc_valid_b); end
            n_checks++; if (err_sticky_b !== 1'b0 || dealloc_err_b !== 3'b000) begin
               n_fail++; $display("FAIL t6_rst_err: got %b/%b want 0/000", err_sticky_b, dealloc_err_b);
            end
         end

         alloc_req_b = 1'($urandom_range(0, 1));
         for (int p = 0; p < 3; p++) begin
            dealloc_req_b[p] = ($urandom_range(0, 9) < 3);
            idp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            dealloc_id_b[p*4 +: 4] = idp;
         end
         #1;

         fire  = alloc_req_b && alloc_valid_b;
         n_use = m_use;
         if (fire) begin
            n_checks++;
            if (alloc_id_b >= 4'd8 || m_use[alloc_id_b[2:0]]) begin
               n_fail++; $display("FAIL t6_grant_owned[%0d]: got id %0d which is not free", cyc, alloc_id_b);
            end
            if (alloc_id_b < 4'd8) n_use[alloc_id_b[2:0]] = 1'b1;
         end
         acc = 3'b000;
         for (int p = 0; p < 3; p++) begin
            idp = dealloc_id_b[p*4 +: 4];
            ok  = dealloc_req_b[p] && (idp < 4'd8) && m_use[idp[2:0]];
            for (int q = 0; q < p; q++) begin
               if (acc[q] && dealloc_id_b[q*4 +: 4] == idp) ok = 1'b0;
            end
            acc[p] = ok;
            if (ok) n_use[idp[2:0]] = 1'b0;
         end
         exp_err  = dealloc_req_b & ~acc;
         m_sticky = m_sticky | (|exp_err);
         m_use    = n_use;

         @(posedge clk);
         #1;
         pc = int'(popcount(64'(m_use)));
         n_checks++; if (free_count_b !== 4'(8 - pc)) begin
            n_fail++; $display("FAIL t6_invariant[%0d]: got %0d want %0d", cyc, free_count_b, 8 - pc);
         end
         n_checks++; if (dealloc_err_b !== exp_err) begin
            n_fail++; $display("FAIL t6_err[%0d]: got %b want %b", cyc, dealloc_err_b, exp_err);
         end
         n_checks++; if (err_sticky_b !== m_sticky) begin
            n_fail++; $display("FAIL t6_sticky[%0d]: got %b want %b", cyc, err_sticky_b, m_sticky);
         end
         n_checks++; if (alloc_valid_b !== (pc != 8)) begin
            n_fail++; $display("FAIL t6_valid[%0d]: got %b want %b", cyc, alloc_valid_b, (pc != 8));
         end
      end
      alloc_req_b   = 1'b0;
      dealloc_req_b = 3'b000;
   endtask

   initial begin
      reset_n       = 1'b0;
      alloc_req     = 1'b0;
      dealloc_req   = 2'b00;
      dealloc_id    = 8'h00;
      reset_n_b     = 1'b0;
      alloc_req_b   = 1'b0;
      dealloc_req_b = 3'b000;
      dealloc_id_b  = 12'h000;
      #1;
      test_reset();
      test_alloc_all();
      test_dual_return();
      test_dup_return();
      test_alloc_at_empty();
      test_never_issued();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
